// File: rtl/divider_core.sv
// Sequential unsigned restoring divider: one quotient bit per clock, start/busy/finish handshake.
// A zero divisor yields an all-ones quotient, so the top bit flags the error.
module divider_core #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    input  logic             start_i,
    output logic             busy_o,
    output logic             finish_o,
    output logic [WIDTH:0]   quotient_o
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] dvd_q;
    logic [WIDTH-1:0] dvs_q;
    logic [CNT_W-1:0] cnt_q;

    logic [WIDTH:0]   shifted_c;
    logic             ge_c;
    logic [WIDTH-1:0] rem_nxt_c;
    logic [WIDTH-1:0] dvd_nxt_c;

    // One restoring step; the dividend register fills with quotient bits from the right.
    always_comb begin
        shifted_c = {rem_q, dvd_q[WIDTH-1]};
        ge_c      = (shifted_c >= {1'b0, dvs_q});
        rem_nxt_c = shifted_c[WIDTH-1:0];
        if (ge_c) begin
            rem_nxt_c = WIDTH'(shifted_c - {1'b0, dvs_q});
        end
        dvd_nxt_c = {dvd_q[WIDTH-2:0], ge_c};
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state      <= IDLE;
            rem_q      <= '0;
            dvd_q      <= '0;
            dvs_q      <= '0;
            cnt_q      <= '0;
            busy_o     <= 1'b0;
            finish_o   <= 1'b0;
            quotient_o <= '0;
        end else begin
            case (state)
                IDLE: begin
                    finish_o <= 1'b0;
                    if (start_i) begin
                        dvd_q  <= dividend_i;
                        dvs_q  <= divisor_i;
                        rem_q  <= '0;
                        cnt_q  <= '0;
                        busy_o <= 1'b1;
                        state  <= CALC;
                    end
                end
                CALC: begin
                    rem_q <= rem_nxt_c;
                    dvd_q <= dvd_nxt_c;
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        quotient_o <= (dvs_q == '0) ? '1 : {1'b0, dvd_nxt_c};
                        finish_o   <= 1'b1;
                        state      <= DONE;
                    end
                end
                DONE: begin
                    finish_o <= 1'b0;
                    busy_o   <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    finish_o <= 1'b0;
                    busy_o   <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_divider_core.sv
// Scoreboard bench for divider_core: driver queues expected quotient and finish cycle,
// a negedge monitor checks every finish pulse against the queue.
module tb_divider_core;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] dividend;
    logic [7:0] divisor;
    logic       start;
    logic       busy_o;
    logic       finish_o;
    logic [8:0] quotient_o;

    typedef struct {
        logic [8:0] q;
        int         cyc;
    } exp_t;

    exp_t       sb[$];
    int         cyc    = 0;
    int         tests  = 0;
    int         fails  = 0;
    logic [8:0] last_q = '0;

    divider_core #(.WIDTH(8)) dut (
        .clk_i      (clk),
        .reset_i    (rst_n),
        .dividend_i (dividend),
        .divisor_i  (divisor),
        .start_i    (start),
        .busy_o     (busy_o),
        .finish_o   (finish_o),
        .quotient_o (quotient_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every finish pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && finish_o === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_finish", 32'(finish_o), 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("quotient", 32'(quotient_o), 32'(e.q));
                check("finish_cycle", 32'(cyc), 32'(e.cyc));
                check("error_bit", 32'(quotient_o[8]), 32'(e.q[8]));
            end
        end
    end

    task automatic run_div(input logic [7:0] a, input logic [7:0] b, input logic [8:0] exp,
                           input int hold, input bit disturb);
        int acc;
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk);
        #1;
        acc = cyc;
        sb.push_back('{q: exp, cyc: acc + 8});
        check("busy_after_accept", 32'(busy_o), 32'd1);
        check("q_holds_on_accept", 32'(quotient_o), 32'(last_q));
        for (int i = 1; i < hold; i++) begin
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        if (disturb) begin
            @(negedge clk);
            dividend = 8'd10;
            divisor  = 8'd10;
            start    = 1'b1;
            @(negedge clk);
            start = 1'b0;
            check("busy_during_calc", 32'(busy_o), 32'd1);
        end
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #2;
            if (sb.size() == 0) break;
        end
        if (sb.size() != 0) begin
            check("finish_timeout", 32'(sb.size()), 32'd0);
            sb.delete();
        end
        check("finish_single_cycle", 32'(finish_o), 32'd0);
        check("busy_cleared", 32'(busy_o), 32'd0);
        check("q_holds_after", 32'(quotient_o), 32'(exp));
        last_q = exp;
    endtask

    initial begin
        rst_n    = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_busy", 32'(busy_o), 32'd0);
        check("reset_finish", 32'(finish_o), 32'd0);
        check("reset_quotient", 32'(quotient_o), 32'd0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_no_start", 32'(busy_o), 32'd0);

        run_div(8'd100, 8'd7,   9'd14,    2, 1'b0);
        run_div(8'd255, 8'd1,   9'd255,   1, 1'b0);
        run_div(8'd255, 8'd255, 9'd1,     1, 1'b0);
        run_div(8'd0,   8'd5,   9'd0,     1, 1'b0);
        run_div(8'd5,   8'd200, 9'd0,     1, 1'b0);
        run_div(8'd128, 8'd2,   9'd64,    1, 1'b0);
        run_div(8'd37,  8'd0,   9'h1FF,   1, 1'b0);
        run_div(8'd200, 8'd3,   9'd66,    1, 1'b1);

        // Abort mid-operation: outputs clear at once and no finish follows.
        dividend = 8'd50;
        divisor  = 8'd5;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(busy_o), 32'd0);
        check("abort_finish", 32'(finish_o), 32'd0);
        check("abort_quotient", 32'(quotient_o), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        check("abort_stays_idle", 32'(busy_o), 32'd0);
        last_q = '0;

        run_div(8'd9, 8'd3, 9'd3, 1, 1'b0);

        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
